// File: rtl/div_signed_seq.sv
// Signed front end for the unsigned shift/subtract divider: takes signed operand
// pairs, runs the divider on magnitudes, then sign-corrects and flags dbz/overflow.
module div_signed_seq #(
  parameter int N = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         div_start,
  output logic [N-1:0] div_abus,
  output logic [N-1:0] div_bbus,
  input  logic [N-1:0] div_qbus,
  input  logic [N-1:0] div_rbus,
  input  logic         div_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q_out,
  output logic [N-1:0] r_out,
  output logic         dbz,
  output logic         ovf
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FIX, OUT} state_t;

  localparam logic [N-1:0] MIN_MAG = {1'b1, {(N-1){1'b0}}};

  state_t       state;
  logic         sign_a, sign_b, zero_div;
  logic [N-1:0] raw_a, q_mag, r_mag;
  logic [N-1:0] a_mag, b_mag;

  // -2^(N-1) negates to itself, which read as unsigned is exactly its magnitude
  assign a_mag = a_in[N-1] ? -a_in : a_in;
  assign b_mag = b_in[N-1] ? -b_in : b_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      div_start <= 1'b0;
      out_valid <= 1'b0;
      div_abus  <= '0;
      div_bbus  <= '0;
      q_out     <= '0;
      r_out     <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      zero_div  <= 1'b0;
      raw_a     <= '0;
      q_mag     <= '0;
      r_mag     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          sign_a   <= a_in[N-1];
          sign_b   <= b_in[N-1];
          raw_a    <= a_in;
          zero_div <= (b_in == '0);
          in_ready <= 1'b0;
          if (b_in == '0) begin
            state <= FIX;
          end else begin
            div_abus  <= a_mag;
            div_bbus  <= b_mag;
            div_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          div_start <= 1'b0;
          state     <= WAIT_BUSY;
        end
        // a ready still high from the previous op must not be mistaken for completion
        WAIT_BUSY: if (!div_ready) state <= WAIT_DONE;
        WAIT_DONE: if (div_ready) begin
          q_mag <= div_qbus;
          r_mag <= div_rbus;
          state <= FIX;
        end
        FIX: begin
          if (zero_div) begin
            q_out <= '0;
            r_out <= raw_a;
            dbz   <= 1'b1;
            ovf   <= 1'b0;
          end else begin
            q_out <= (sign_a ^ sign_b) ? -q_mag : q_mag;
            r_out <= sign_a ? -r_mag : r_mag;
            dbz   <= 1'b0;
            ovf   <= !(sign_a ^ sign_b) && (q_mag == MIN_MAG);
          end
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_signed_seq.sv
// Randomized bench for div_signed_seq with a stub divider and a signed-arithmetic
// reference model; directed cases pin the model with literal results.
module tb_div_signed_seq;
  localparam int N = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a_in = '0, b_in = '0;
  logic         div_start;
  logic [N-1:0] div_abus, div_bbus, div_qbus, div_rbus;
  logic         div_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] q_out, r_out;
  logic         dbz, ovf;

  int n_vec = 0, n_err = 0;
  int cyc = 0, starts = 0, lowcnt = 0, force_t = 0;
  bit seen = 0;

  typedef struct {
    logic [N-1:0] q, r, ma, mb;
    logic         dbz, ovf;
    int           acc;
  } exp_t;
  exp_t exp_q[$];
  exp_t acc_e;

  always #5 clk = ~clk;

  div_signed_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .div_start(div_start), .div_abus(div_abus),
    .div_bbus(div_bbus), .div_qbus(div_qbus), .div_rbus(div_rbus),
    .div_ready(div_ready), .out_valid(out_valid), .out_ready(out_ready),
    .q_out(q_out), .r_out(r_out), .dbz(dbz), .ovf(ovf)
  );

  // stub unsigned divider: ready low for a random number of cycles after start
  logic [N-1:0] sa, sb;
  int busy;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_ready <= 1'b1; busy <= 0; div_qbus <= '0; div_rbus <= '0; sa <= '0; sb <= '0;
    end else if (div_start) begin
      div_ready <= 1'b0;
      busy      <= (force_t != 0) ? force_t : int'($urandom_range(1, 12));
      sa        <= div_abus;
      sb        <= div_bbus;
    end else if (!div_ready) begin
      if (busy <= 1) begin
        div_ready <= 1'b1;
        div_qbus  <= sa / sb;
        div_rbus  <= sa % sb;
      end else busy <= busy - 1;
    end
  end

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int as, bs, qi, ri, ma, mb;
    as = $signed(a);
    bs = $signed(b);
    ma = (as < 0) ? -as : as;
    mb = (bs < 0) ? -bs : bs;
    e.ma = ma[N-1:0];
    e.mb = mb[N-1:0];
    e.acc = 0;
    if (bs == 0) begin
      e.q = '0; e.r = a; e.dbz = 1'b1; e.ovf = 1'b0;
    end else begin
      qi = as / bs;
      ri = as % bs;
      e.q = qi[N-1:0];
      e.r = ri[N-1:0];
      e.dbz = 1'b0;
      e.ovf = (qi == (1 << (N-1)));
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event absent, required present", name);
  endtask

  always @(negedge rst) begin
    exp_q.delete();
    starts = 0; lowcnt = 0; seen = 0;
  end

  always @(posedge clk) begin
    if (rst && in_valid && in_ready) begin
      acc_e = model(a_in, b_in);
      acc_e.acc = cyc;
      exp_q.push_back(acc_e);
    end
    if (rst && out_valid && out_ready && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      starts = 0; lowcnt = 0; seen = 0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (!div_ready && exp_q.size() != 0) lowcnt++;
      if (div_start) begin
        starts++;
        if (exp_q.size() == 0) fail_now("start_without_txn");
        else begin
          chk("div_abus", div_abus, exp_q[0].ma);
          chk("div_bbus", div_bbus, exp_q[0].mb);
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) fail_now("out_without_txn");
        else begin
          chk("q_out", q_out, exp_q[0].q);
          chk("r_out", r_out, exp_q[0].r);
          chk("dbz", dbz, exp_q[0].dbz);
          chk("ovf", ovf, exp_q[0].ovf);
          chk("in_ready_while_out", in_ready, 0);
          if (!seen) begin
            seen = 1;
            chk("latency", cyc - exp_q[0].acc, exp_q[0].dbz ? 2 : 4 + lowcnt);
            chk("start_count", starts, exp_q[0].dbz ? 0 : 1);
          end
        end
      end
    end
  end

  task automatic txn(input logic [N-1:0] a, input logic [N-1:0] b, input int hold, input bit lit,
                     input logic [N-1:0] eq, input logic [N-1:0] er, input logic ed, input logic eo);
    int t;
    @(negedge clk);
    in_valid = 1'b1; a_in = a; b_in = b;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin fail_now("accept_timeout"); in_valid = 1'b0; return; end
    @(negedge clk);
    in_valid = 1'b0; a_in = N'($urandom); b_in = N'($urandom);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    if (!out_valid) begin fail_now("result_timeout"); return; end
    if (lit) begin
      chk("lit_q", q_out, eq);
      chk("lit_r", r_out, er);
      chk("lit_dbz", dbz, ed);
      chk("lit_ovf", ovf, eo);
    end
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_abus", div_abus, 0);
    chk("rst_div_bbus", div_bbus, 0);
    chk("rst_q_out", q_out, 0);
    chk("rst_r_out", r_out, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;

    txn(9'd100, 9'd7,   0, 1, 9'h00E, 9'h002, 1'b0, 1'b0);
    txn(9'h19C, 9'd7,   0, 1, 9'h1F2, 9'h1FE, 1'b0, 1'b0);
    txn(9'd100, 9'h1F9, 0, 1, 9'h1F2, 9'h002, 1'b0, 1'b0);
    txn(9'h100, 9'h1FF, 0, 1, 9'h100, 9'h000, 1'b0, 1'b1);
    txn(9'd5,   9'd0,   0, 1, 9'h000, 9'h005, 1'b1, 1'b0);
    txn(9'd100, 9'd7,  10, 1, 9'h00E, 9'h002, 1'b0, 1'b0);
    chk("in_ready_after_out", in_ready, 1);

    // reset while the divider is busy, state WAIT_DONE
    force_t = 10;
    @(negedge clk);
    in_valid = 1'b1; a_in = 9'd50; b_in = 9'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_div_start", div_start, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_q_out", q_out, 0);
    @(negedge clk);
    rst = 1'b1;
    force_t = 0;
    txn(9'd9, 9'd3, 0, 1, 9'h003, 9'h000, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [N-1:0] a, b;
      int sel;
      sel = $urandom_range(0, 9);
      a = N'($urandom);
      b = N'($urandom);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 9'h100; b = 9'h1FF; end
      else if (sel == 2) b = 9'h1FF;
      else if (sel == 3) b = 9'h001;
      else if (sel == 4) a = 9'h100;
      txn(a, b, $urandom_range(0, 3), 1'b0, '0, '0, 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
